charlie_matrix: RTL and testbench

//  Wishbone-B4 classic slave driving a charlieplexed LED matrix on PINS tristate pins.

---
 rtl/charlie_matrix_pkg.sv | 24 ++
 rtl/charlie_scan.sv | 72 +++++++
 rtl/charlie_matrix.sv | 164 ++++++++++++++++
 tb/tb_charlie_matrix.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/charlie_matrix_pkg.sv
`default_nettype none
// ============================================================================
// Module : charlie_matrix_pkg
// Shared types and constants for the charlieplex matrix driver.
// Optional feature macro: CHARLIE_MATRIX_PWM_EN (see charlie_matrix).
// Rev    : 1.0  initial release
// ============================================================================
package charlie_matrix_pkg;

    localparam int c_WB_DW    = 16;
    localparam int c_REG_ROW0 = 0;

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_e;

    // BRIGHT sits directly after the last row register.
    function automatic int f_reg_bright(input int pins);
        return c_REG_ROW0 + pins;
    endfunction

endpackage
`default_nettype wire

// File: rtl/charlie_scan.sv
`default_nettype none
// ============================================================================
// Module : charlie_scan
// Row and tick sequencer: alternates a blanking gap and a drive dwell per row.
// Rev    : 1.0  initial release
// ============================================================================
module charlie_scan
    import charlie_matrix_pkg::*;
#(
    parameter  int PINS        = 7,
    parameter  int DWELL_TICKS = 64,
    parameter  int BLANK_TICKS = 2,
    localparam int c_ROW_W     = $clog2(PINS),
    localparam int c_CNT_W     = $clog2((DWELL_TICKS > BLANK_TICKS) ? DWELL_TICKS : BLANK_TICKS)
) (
    input  logic               clk,
    input  logic               rst,
    output logic [c_ROW_W-1:0] row_o,
    output scan_state_e        state_o,
    output logic [c_CNT_W-1:0] cnt_o,
    output logic               latch_o
);

    scan_state_e        state_q;
    logic [c_CNT_W-1:0] cnt_q;
    logic [c_ROW_W-1:0] row_q;
    logic               w_blank_done;
    logic               w_dwell_done;

    assign w_blank_done = (state_q == ST_BLANK) && (cnt_q == c_CNT_W'(BLANK_TICKS - 1));
    assign w_dwell_done = (state_q == ST_DRIVE) && (cnt_q == c_CNT_W'(DWELL_TICKS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_BLANK;
            cnt_q   <= '0;
            row_q   <= '0;
        end else begin
            case (state_q)
                ST_BLANK: begin
                    if (w_blank_done) begin
                        state_q <= ST_DRIVE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + c_CNT_W'(1);
                    end
                end
                ST_DRIVE: begin
                    if (w_dwell_done) begin
                        state_q <= ST_BLANK;
                        cnt_q   <= '0;
                        row_q   <= (row_q == c_ROW_W'(PINS - 1)) ? '0 : row_q + c_ROW_W'(1);
                    end else begin
                        cnt_q <= cnt_q + c_CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_BLANK;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Strobe is high in the cycle whose closing edge enters DRIVE.
    assign latch_o = w_blank_done;
    assign row_o   = row_q;
    assign state_o = state_q;
    assign cnt_o   = cnt_q;

endmodule
`default_nettype wire

// File: rtl/charlie_matrix.sv
`default_nettype none
// ============================================================================
// Module : charlie_matrix
// Wishbone-B4 classic slave with framebuffer driving a charlieplexed LED matrix.
// Define CHARLIE_MATRIX_PWM_EN to add the BRIGHT global dimming register.
// Rev    : 1.0  initial release
// ============================================================================
module charlie_matrix
    import charlie_matrix_pkg::*;
#(
    parameter int PINS        = 7,
    parameter int DWELL_TICKS = 64,
    parameter int BLANK_TICKS = 2,
    parameter int AW          = $clog2(PINS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wb_cyc_i,
    input  logic               wb_stb_i,
    input  logic               wb_we_i,
    input  logic [AW-1:0]      wb_adr_i,
    input  logic [c_WB_DW-1:0] wb_dat_i,
    output logic [c_WB_DW-1:0] wb_dat_o,
    output logic               wb_ack_o,
    output logic [PINS-1:0]    charlie_o,
    output logic [PINS-1:0]    charlie_oe
);

    localparam int            c_ROW_W      = $clog2(PINS);
    localparam int            c_CNT_W      = $clog2((DWELL_TICKS > BLANK_TICKS) ? DWELL_TICKS : BLANK_TICKS);
    localparam logic [AW-1:0] c_ADR_BRIGHT = AW'(f_reg_bright(PINS));

    logic [c_ROW_W-1:0]         w_row;
    scan_state_e                w_state;
    logic [c_CNT_W-1:0]         w_cnt;
    logic                       w_latch;

    logic [PINS-1:0][PINS-1:0]  fb_q;
    logic [PINS-1:0]            shadow_q;
    logic                       ack_q;
    logic [c_WB_DW-1:0]         dat_q;
    logic [PINS-1:0]            pin_o_q;
    logic [PINS-1:0]            pin_oe_q;

    logic                       w_req;
    logic                       w_wr;
    logic                       w_row_hit;
    logic [c_ROW_W-1:0]         w_adr_row;
    logic [PINS-1:0]            w_anode;
    logic                       w_lit;
    logic [c_WB_DW-1:0]         w_rd_data;

    charlie_scan #(
        .PINS        (PINS),
        .DWELL_TICKS (DWELL_TICKS),
        .BLANK_TICKS (BLANK_TICKS)
    ) u_scan (
        .clk     (clk),
        .rst     (rst),
        .row_o   (w_row),
        .state_o (w_state),
        .cnt_o   (w_cnt),
        .latch_o (w_latch)
    );

    // Only the first cycle of a strobe is serviced; the ack itself blocks a repeat.
    assign w_req     = wb_cyc_i & wb_stb_i & ~ack_q;
    assign w_wr      = w_req & wb_we_i;
    assign w_row_hit = (wb_adr_i < c_ADR_BRIGHT);
    assign w_adr_row = wb_adr_i[c_ROW_W-1:0];
    assign w_anode   = PINS'(1) << w_row;

    always_ff @(posedge clk) begin
        if (rst) begin
            fb_q <= '0;
        end else if (w_wr && w_row_hit) begin
            fb_q[w_adr_row] <= wb_dat_i[PINS-1:0];
        end
    end

`ifdef CHARLIE_MATRIX_PWM_EN
    localparam int c_BRT_W = $clog2(DWELL_TICKS + 1);

    logic [c_BRT_W-1:0] bright_q;
    logic [c_BRT_W-1:0] bright_lat_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            bright_q     <= c_BRT_W'(DWELL_TICKS);
            bright_lat_q <= c_BRT_W'(DWELL_TICKS);
        end else begin
            if (w_wr && (wb_adr_i == c_ADR_BRIGHT)) begin
                bright_q <= (wb_dat_i > c_WB_DW'(DWELL_TICKS)) ? c_BRT_W'(DWELL_TICKS)
                                                               : wb_dat_i[c_BRT_W-1:0];
            end
            if (w_latch) begin
                bright_lat_q <= bright_q;
            end
        end
    end

    assign w_lit = (32'(w_cnt) < 32'(bright_lat_q));
`else
    logic w_unused_cnt;
    assign w_unused_cnt = ^w_cnt;
    assign w_lit        = 1'b1;

    if (PINS < c_WB_DW) begin : g_dat_unused
        logic w_unused_dat;
        assign w_unused_dat = ^wb_dat_i[c_WB_DW-1:PINS];
    end
`endif

    always_comb begin
        w_rd_data = '0;
        if (w_row_hit) begin
            w_rd_data[PINS-1:0] = fb_q[w_adr_row];
        end
`ifdef CHARLIE_MATRIX_PWM_EN
        else if (wb_adr_i == c_ADR_BRIGHT) begin
            w_rd_data[c_BRT_W-1:0] = bright_q;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= w_req;
            dat_q <= (w_req && !wb_we_i) ? w_rd_data : '0;
        end
    end

    // Shadow is captured on the entry edge, so a same-edge write lands next frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
        end else if (w_latch) begin
            shadow_q <= fb_q[w_row] & ~w_anode;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pin_o_q  <= '0;
            pin_oe_q <= '0;
        end else if (w_state == ST_DRIVE) begin
            pin_o_q  <= w_anode;
            pin_oe_q <= ((shadow_q != '0) && w_lit) ? (w_anode | shadow_q) : '0;
        end else begin
            pin_o_q  <= '0;
            pin_oe_q <= '0;
        end
    end

    assign wb_ack_o   = ack_q;
    assign wb_dat_o   = dat_q;
    assign charlie_o  = pin_o_q;
    assign charlie_oe = pin_oe_q;

endmodule
`default_nettype wire

// File: tb/tb_charlie_matrix.sv
`default_nettype none
// ============================================================================
// Module : tb_charlie_matrix
// Scoreboard bench for charlie_matrix (PINS=7, DWELL=4, BLANK=1), random WB traffic.
// Rev    : 1.0  initial release
// ============================================================================
module tb_charlie_matrix;

    localparam int P     = 7;
    localparam int DW    = 4;
    localparam int BT    = 1;
    localparam int AW    = 4;
    localparam int SLOT  = DW + BT;
    localparam int FRAME = P * SLOT;

    logic          clk = 1'b0;
    logic          rst;
    logic          wb_cyc_i, wb_stb_i, wb_we_i;
    logic [AW-1:0] wb_adr_i;
    logic [15:0]   wb_dat_i;
    logic [15:0]   wb_dat_o;
    logic          wb_ack_o;
    logic [P-1:0]  charlie_o, charlie_oe;

    always #5 clk = ~clk;

    charlie_matrix #(
        .PINS(P), .DWELL_TICKS(DW), .BLANK_TICKS(BT), .AW(AW)
    ) dut (
        .clk(clk), .rst(rst),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
        .charlie_o(charlie_o), .charlie_oe(charlie_oe)
    );

    int vectors     = 0;
    int miscompares = 0;
    bit mon_en      = 1'b0;

    // Reference model: timeline position derived from edges since reset.
    logic [15:0] fb_m [P];
    logic [15:0] shadow_m;
    int          bright_m, bright_l;
    int          k;
    bit          ack_m;
    logic [15:0] exp_o, exp_oe;
    logic [15:0] rdq [$];
    int          mq, mrow, msub;
    bit          mreq;

    always @(posedge clk) begin
        if (rst) begin
            k = 0;
            foreach (fb_m[i]) fb_m[i] = 16'h0;
            shadow_m = 16'h0;
            bright_m = DW;
            bright_l = DW;
            ack_m    = 1'b0;
            exp_o    = 16'h0;
            exp_oe   = 16'h0;
        end else begin
            k++;
            exp_o  = 16'h0;
            exp_oe = 16'h0;
            if (k >= 2) begin
                mq   = (k - 2) % FRAME;
                mrow = mq / SLOT;
                msub = mq % SLOT;
                if (msub < DW) begin
                    exp_o = 16'h1 << mrow;
                    if (shadow_m != 16'h0 && msub < bright_l) exp_oe = exp_o | shadow_m;
                end
            end
            mq = (k - 1) % FRAME;
            if (mq % SLOT == 0) begin
                mrow     = mq / SLOT;
                shadow_m = fb_m[mrow] & ~(16'h1 << mrow);
                bright_l = bright_m;
            end
            mreq = wb_cyc_i && wb_stb_i && !ack_m;
            if (mreq && wb_we_i) begin
                if (int'(wb_adr_i) < P) fb_m[wb_adr_i] = wb_dat_i & 16'h007F;
`ifdef CHARLIE_MATRIX_PWM_EN
                else if (int'(wb_adr_i) == P) bright_m = (int'(wb_dat_i) > DW) ? DW : int'(wb_dat_i);
`endif
            end
            ack_m = mreq;
        end
    end

    function automatic logic [15:0] model_read(input logic [AW-1:0] adr);
        if (int'(adr) < P) return fb_m[adr];
`ifdef CHARLIE_MATRIX_PWM_EN
        if (int'(adr) == P) return 16'(bright_m);
`endif
        return 16'h0;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at t=%0t: got 0x%04h expected 0x%04h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("charlie_o", 16'(charlie_o), exp_o);
            chk("charlie_oe", 16'(charlie_oe), exp_oe);
            chk("wb_ack_o", 16'(wb_ack_o), 16'(ack_m));
            if (wb_ack_o === 1'b1) begin
                if (rdq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_ack at t=%0t: got ack with no pending request", $time);
                end else begin
                    chk("wb_dat_o", wb_dat_o, rdq.pop_front());
                end
            end else begin
                chk("wb_dat_o_idle", wb_dat_o, 16'h0);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wb_xfer(input bit we, input logic [AW-1:0] adr, input logic [15:0] dat);
        bit got;
        got = 1'b0;
        rdq.push_back(we ? 16'h0 : model_read(adr));
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (wb_ack_o === 1'b1) begin got = 1'b1; break; end
        end
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL ack_timeout adr=%0d: got no ack expected ack within 4 cycles", adr);
            void'(rdq.pop_back());
        end
        @(posedge clk); #1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    endtask

    // Strobe held for three edges: acks expected on the first and third.
    task automatic wb_hold_read(input logic [AW-1:0] adr);
        rdq.push_back(model_read(adr));
        rdq.push_back(model_read(adr));
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = adr;
        repeat (3) @(posedge clk);
        #1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        wb_adr_i = '0;   wb_dat_i = 16'h0;
        @(posedge clk); #1;
        mon_en = 1'b1;
        idle(2);
        rst = 1'b0;

        for (int a = 0; a < P; a++) wb_xfer(1'b0, AW'(a), 16'h0);
        idle(FRAME);

        wb_xfer(1'b1, AW'(2), 16'h0005);
        wb_xfer(1'b1, AW'(3), 16'h007F);
        idle(2 * FRAME);

        wb_hold_read(AW'(3));
        idle(2);

        wb_xfer(1'b0, AW'(9), 16'h0);
        wb_xfer(1'b1, AW'(9), 16'hFFFF);
        wb_xfer(1'b0, AW'(9), 16'h0);
        wb_xfer(1'b0, AW'(2), 16'h0);
        wb_xfer(1'b0, AW'(3), 16'h0);

        for (int i = 0; i < 2 * FRAME; i++) begin
            @(posedge clk); #1;
            if (k >= 1 && ((k - 1) % FRAME) == SLOT + 1) break;
        end
        wb_xfer(1'b1, AW'(1), 16'h0041);
        idle(2 * FRAME + 5);

`ifdef CHARLIE_MATRIX_PWM_EN
        wb_xfer(1'b1, AW'(P), 16'd2);
        idle(2 * FRAME);
        wb_xfer(1'b1, AW'(P), 16'd0);
        idle(2 * FRAME);
        wb_xfer(1'b1, AW'(P), 16'd9);
        wb_xfer(1'b0, AW'(P), 16'h0);
        idle(FRAME);
`endif

        for (int i = 0; i < 150; i++) begin
            wb_xfer(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), 16'($urandom));
            idle($urandom_range(0, 6));
        end

        idle($urandom_range(10, 30));
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        for (int a = 0; a < P; a++) wb_xfer(1'b0, AW'(a), 16'h0);

        for (int i = 0; i < 40; i++) begin
            wb_xfer(1'($urandom_range(0, 1)), AW'($urandom_range(0, P)), 16'($urandom));
            idle($urandom_range(0, 4));
        end
        idle(2 * FRAME);

        if (rdq.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL pending_acks: got %0d outstanding expected 0", rdq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
